// File: rtl/signed_shft_div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default widths and a conditional two's-complement negate helper.
package signed_div_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 2 * N_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } state_t;

    // Callers zero-extend into 64 bits and truncate the result back; the low
    // bits of a negate are unaffected by the extension.
    function automatic logic [63:0] cond_neg(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/signed_shft_div_if.sv
// Start/done handshake bundle shared with the shift-add multiplier.
interface signed_shft_div_if #(
    parameter int N  = 4,
    parameter int DW = 2 * N
);
    logic [DW-1:0] a;
    logic [N-1:0]  b;
    logic          start;
    logic [DW-1:0] q;
    logic [N-1:0]  r;
    logic          done;
    logic          busy;
    logic          div0;
    logic          ovf;

    modport master (output a, b, start, input q, r, done, busy, div0, ovf);
    modport slave  (input a, b, start, output q, r, done, busy, div0, ovf);
endinterface

// File: rtl/signed_shft_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the
// divisor magnitude when it fits.
module div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] rem_in,
    input  logic         dbit,
    input  logic [N-1:0] bmag,
    output logic [N-1:0] rem_out,
    output logic         qbit
);
    logic [N:0] shifted;

    // rem_in < bmag <= 2^(N-1), so the shifted value fits N+1 bits and the
    // restored remainder always fits back into N bits.
    always_comb begin
        shifted = {rem_in, dbit};
        qbit    = (shifted >= {1'b0, bmag});
        rem_out = qbit ? N'(shifted - {1'b0, bmag}) : shifted[N-1:0];
    end
endmodule

// File: rtl/signed_shft_div.sv
// Sequential signed restoring divider: magnitudes are divided one quotient
// bit per clock, then signs are reapplied in a final fix-up cycle.
module signed_shft_div
    import signed_div_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = 2 * N
) (
    input logic            clk,
    input logic            rst,
    signed_shft_div_if.slave bus
);
    localparam int CW = $clog2(DW);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          sa_reg, sa_next, sb_reg, sb_next;
    logic [DW-1:0] dq_reg, dq_next;     // dividend shifts out the top, quotient fills the bottom
    logic [N-1:0]  bmag_reg, bmag_next;
    logic [N-1:0]  rem_reg, rem_next;
    logic [DW-1:0] q_reg, q_next;
    logic [N-1:0]  r_reg, r_next;
    logic          done_reg, done_next, busy_reg, busy_next;
    logic          div0_reg, div0_next, ovf_reg, ovf_next;
    logic [N-1:0]  step_rem;
    logic          step_qbit;

    div_step #(.N(N)) u_step (
        .rem_in (rem_reg),
        .dbit   (dq_reg[DW-1]),
        .bmag   (bmag_reg),
        .rem_out(step_rem),
        .qbit   (step_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            dq_reg    <= '0;
            bmag_reg  <= '0;
            rem_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            div0_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            dq_reg    <= dq_next;
            bmag_reg  <= bmag_next;
            rem_reg   <= rem_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            div0_reg  <= div0_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        dq_next    = dq_reg;
        bmag_next  = bmag_reg;
        rem_next   = rem_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        done_next  = 1'b0;
        busy_next  = busy_reg;
        div0_next  = div0_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    sa_next    = bus.a[DW-1];
                    sb_next    = bus.b[N-1];
                    dq_next    = DW'(cond_neg(bus.a[DW-1], 64'(bus.a)));
                    bmag_next  = N'(cond_neg(bus.b[N-1], 64'(bus.b)));
                    rem_next   = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    div0_next  = 1'b0;
                    ovf_next   = 1'b0;
                    state_next = (bus.b == '0) ? DZ : RUN;
                end
            end
            RUN: begin
                rem_next = step_rem;
                dq_next  = {dq_reg[DW-2:0], step_qbit};
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(DW - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                q_next     = DW'(cond_neg(sa_reg ^ sb_reg, 64'(dq_reg)));
                r_next     = N'(cond_neg(sa_reg, 64'(rem_reg)));
                // A positive quotient with its top bit set is only -2^(DW-1) / -1.
                ovf_next   = ~(sa_reg ^ sb_reg) & dq_reg[DW-1];
                cnt_next   = '0;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            DZ: begin
                q_next     = '0;
                r_next     = '0;
                div0_next  = 1'b1;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.q    = q_reg;
    assign bus.r    = r_reg;
    assign bus.done = done_reg;
    assign bus.busy = busy_reg;
    assign bus.div0 = div0_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_signed_shft_div.sv
// Directed self-checking bench for signed_shft_div with N=4, DW=8.
module tb_signed_shft_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    signed_shft_div_if #(.N(4), .DW(8)) bus ();

    signed_shft_div #(.N(4), .DW(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // All tasks enter and leave on a falling edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (bus.done !== 1'b1 && lat < 40);
    endtask

    task automatic test_reset;
        n_checks++; if (bus.q !== 8'h00)  begin n_fail++; $display("FAIL reset_q got %h want 00", bus.q); end
        n_checks++; if (bus.r !== 4'h0)   begin n_fail++; $display("FAIL reset_r got %h want 0", bus.r); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0 got %b want 0", bus.div0); end
        n_checks++; if (bus.ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        $display("reset: q=%h r=%h done=%b busy=%b", bus.q, bus.r, bus.done, bus.busy);
    endtask

    task automatic test_basic;
        int lat;
        launch(8'hF2, 4'h2);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", bus.busy); end
        wait_done(lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency got %0d want 9", lat); end
        n_checks++; if (bus.q !== 8'hF9) begin n_fail++; $display("FAIL basic_q got %h want f9", bus.q); end
        n_checks++; if (bus.r !== 4'h0)  begin n_fail++; $display("FAIL basic_r got %h want 0", bus.r); end
        n_checks++; if (bus.div0 !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL basic_flags got div0=%b ovf=%b want 0 0", bus.div0, bus.ovf); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", bus.busy); end
        $display("op a=f2 b=2: q=%h r=%h lat=%0d", bus.q, bus.r, lat);
        @(posedge clk); @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_signs;
        int lat;
        launch(8'h07, 4'hE);
        wait_done(lat);
        n_checks++; if (bus.q !== 8'hFD) begin n_fail++; $display("FAIL sign_pos_neg_q got %h want fd", bus.q); end
        n_checks++; if (bus.r !== 4'h1)  begin n_fail++; $display("FAIL sign_pos_neg_r got %h want 1", bus.r); end
        $display("op a=07 b=e: q=%h r=%h lat=%0d", bus.q, bus.r, lat);
        @(posedge clk); @(negedge clk);
        launch(8'hF9, 4'h2);
        wait_done(lat);
        n_checks++; if (bus.q !== 8'hFD) begin n_fail++; $display("FAIL sign_neg_pos_q got %h want fd", bus.q); end
        n_checks++; if (bus.r !== 4'hF)  begin n_fail++; $display("FAIL sign_neg_pos_r got %h want f", bus.r); end
        $display("op a=f9 b=2: q=%h r=%h lat=%0d", bus.q, bus.r, lat);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_div0;
        int lat;
        launch(8'h35, 4'h0);
        wait_done(lat);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL div0_latency got %0d want 1", lat); end
        n_checks++; if (bus.div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag got %b want 1", bus.div0); end
        n_checks++; if (bus.q !== 8'h00 || bus.r !== 4'h0) begin n_fail++; $display("FAIL div0_qr got q=%h r=%h want 00 0", bus.q, bus.r); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy got %b want 0", bus.busy); end
        $display("op a=35 b=0: q=%h r=%h div0=%b lat=%0d", bus.q, bus.r, bus.div0, lat);
        @(posedge clk); @(negedge clk);
        launch(8'h09, 4'h3);
        n_checks++; if (bus.div0 !== 1'b0) begin n_fail++; $display("FAIL div0_clear got %b want 0", bus.div0); end
        wait_done(lat);
        n_checks++; if (bus.q !== 8'h03 || bus.r !== 4'h0) begin n_fail++; $display("FAIL div0_next_qr got q=%h r=%h want 03 0", bus.q, bus.r); end
        $display("op a=09 b=3: q=%h r=%h div0=%b lat=%0d", bus.q, bus.r, bus.div0, lat);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_ovf;
        int lat;
        launch(8'h80, 4'hF);
        wait_done(lat);
        n_checks++; if (bus.q !== 8'h80 || bus.r !== 4'h0) begin n_fail++; $display("FAIL ovf_qr got q=%h r=%h want 80 0", bus.q, bus.r); end
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", bus.ovf); end
        $display("op a=80 b=f: q=%h r=%h ovf=%b lat=%0d", bus.q, bus.r, bus.ovf, lat);
        @(posedge clk); @(negedge clk);
        launch(8'h80, 4'h8);
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_on_start got %b want 0", bus.ovf); end
        wait_done(lat);
        n_checks++; if (bus.q !== 8'h10 || bus.r !== 4'h0) begin n_fail++; $display("FAIL ovf_min_qr got q=%h r=%h want 10 0", bus.q, bus.r); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_min_flag got %b want 0", bus.ovf); end
        $display("op a=80 b=8: q=%h r=%h ovf=%b lat=%0d", bus.q, bus.r, bus.ovf, lat);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        int dones;
        int first_lat;
        logic [7:0] q_seen;
        logic [3:0] r_seen;
        dones = 0; first_lat = 0; q_seen = '0; r_seen = '0;
        launch(8'h64, 4'h3);
        // Extra start pulses during RUN must be ignored.
        for (int i = 1; i <= 12; i++) begin
            if (i == 3 || i == 5) begin
                bus.a = 8'h11; bus.b = 4'h0; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++;
                if (dones == 1) begin first_lat = i; q_seen = bus.q; r_seen = bus.r; end
            end
        end
        bus.start = 1'b0;
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignore_start_dones got %0d want 1", dones); end
        n_checks++; if (first_lat != 9) begin n_fail++; $display("FAIL ignore_start_latency got %0d want 9", first_lat); end
        n_checks++; if (q_seen !== 8'h21 || r_seen !== 4'h1) begin n_fail++; $display("FAIL ignore_start_qr got q=%h r=%h want 21 1", q_seen, r_seen); end
        $display("op a=64 b=3 (ignored starts): q=%h r=%h dones=%0d lat=%0d", q_seen, r_seen, dones, first_lat);
        launch(8'h64, 4'h3);
        wait_done(lat);
        // Start in the done cycle is accepted on the very next edge.
        launch(8'h09, 4'h3);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %b want 1", bus.busy); end
        wait_done(lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL b2b_latency got %0d want 9", lat); end
        n_checks++; if (bus.q !== 8'h03 || bus.r !== 4'h0) begin n_fail++; $display("FAIL b2b_qr got q=%h r=%h want 03 0", bus.q, bus.r); end
        $display("op a=09 b=3 (back-to-back): q=%h r=%h lat=%0d", bus.q, bus.r, lat);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones;
        dones = 0;
        launch(8'hF2, 4'h2);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.q !== 8'h00 || bus.r !== 4'h0) begin n_fail++; $display("FAIL midrst_qr got q=%h r=%h want 00 0", bus.q, bus.r); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_done got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", dones); end
        $display("op a=f2 b=2 aborted by reset: dones=%0d", dones);
        launch(8'h64, 4'h3);
        wait_done(lat);
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL midrst_after_latency got %0d want 9", lat); end
        n_checks++; if (bus.q !== 8'h21 || bus.r !== 4'h1) begin n_fail++; $display("FAIL midrst_after_qr got q=%h r=%h want 21 1", bus.q, bus.r); end
        $display("op a=64 b=3 after reset: q=%h r=%h lat=%0d", bus.q, bus.r, lat);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        bus.a = '0;
        bus.b = '0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_signs();
        test_div0();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
